// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer
// Turns a 2-bit lighting mode (off / solid / flash / rainbow) into registered
// colour code, brightness and lamp-enable controls for the colour datapath.
// A programmable prescaler produces a tick every period+1 clocks, and the
// tick paces the flash phases and the rainbow colour steps.
//
// Optional feature: define LED_SEQ_FADE_EN to turn flash mode into a
// "breathe" ramp. S_FLASH_ON ramps brightness down and S_FLASH_OFF ramps it
// back up, with the lamp held on.
module led_mode_sequencer #(
  parameter int DIV_W      = 16,
  parameter int NUM_COLORS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [3:0]       color_code_in,
  input  logic [3:0]       brightness_in,
  input  logic [DIV_W-1:0] period,
  output logic [3:0]       color_code,
  output logic [3:0]       brightness,
  output logic             lamp_on,
  output logic             step,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_SOLID     = 3'd1,
    S_FLASH_ON  = 3'd2,
    S_FLASH_OFF = 3'd3,
    S_RAINBOW   = 3'd4
  } state_t;

  // Palette size widened by one bit so NUM_COLORS=16 still compares correctly.
  localparam logic [4:0] NUM_C    = 5'(NUM_COLORS);
  localparam logic [3:0] IDX_LAST = 4'(NUM_COLORS - 1);

  state_t           state_q;
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] cnt;
  logic [3:0]       idx;

  logic             mode_chg;
  logic             tick;
  logic [3:0]       idx_next;
  logic [3:0]       idx_start;
  state_t           entry_state;

  assign state = state_q;

  // A mode change wins over a tick on the same edge. The prescaler is idle in S_OFF.
  assign mode_chg  = (mode != mode_q);
  assign tick      = (state_q != S_OFF) && !mode_chg && (cnt >= period);
  assign idx_next  = (idx == IDX_LAST) ? 4'd0 : idx + 4'd1;
  assign idx_start = ({1'b0, color_code_in} < NUM_C) ? color_code_in : 4'd0;

  // Entry state for the requested mode.
  always_comb begin
    // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
    entry_state = S_OFF;
    case (mode)
      2'd1:    entry_state = S_SOLID;
      2'd2:    entry_state = S_FLASH_ON;
      2'd3:    entry_state = S_RAINBOW;
      default: entry_state = S_OFF;
    endcase
  end

  // Sequencer FSM, prescaler, rainbow index and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here is control state with a defined reset value.
      // There is no storage array that could be left unreset.
      state_q    <= S_OFF;
      mode_q     <= 2'd0;
      cnt        <= '0;
      idx        <= 4'd0;
      color_code <= 4'd0;
      brightness <= 4'd0;
      lamp_on    <= 1'b0;
      step       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // right-hand side sees the pre-edge values.
      mode_q <= mode;
      step   <= 1'b0;

      if (mode_chg) begin
        state_q <= entry_state;
        cnt     <= '0;
        case (entry_state)
          S_OFF: begin
            color_code <= 4'd0;
            brightness <= 4'd0;
            lamp_on    <= 1'b0;
          end
          S_RAINBOW: begin
            idx        <= idx_start;
            color_code <= idx_start;
            brightness <= brightness_in;
            lamp_on    <= 1'b1;
          end
          default: begin
            // Solid and flash (or breathe) both start at the requested colour and brightness.
            color_code <= color_code_in;
            brightness <= brightness_in;
            lamp_on    <= 1'b1;
          end
        endcase
      end else begin
        if (tick || state_q == S_OFF) cnt <= '0;
        else                          cnt <= cnt + DIV_W'(1);

        step <= tick && (state_q != S_SOLID);

        case (state_q)
          S_OFF: begin
            color_code <= 4'd0;
            brightness <= 4'd0;
            lamp_on    <= 1'b0;
          end

          S_SOLID: begin
            color_code <= color_code_in;
            brightness <= brightness_in;
            lamp_on    <= 1'b1;
          end

`ifdef LED_SEQ_FADE_EN
          // Ramp down one level per tick. Reaching zero turns the ramp upward.
          S_FLASH_ON: begin
            color_code <= color_code_in;
            lamp_on    <= 1'b1;
            if (tick) begin
              if (brightness == 4'd0) begin
                state_q <= S_FLASH_OFF;
              end else begin
                brightness <= brightness - 4'd1;
                if (brightness == 4'd1) state_q <= S_FLASH_OFF;
              end
            end
          end

          // Ramp up one level per tick toward brightness_in. If brightness_in drops
          // below the current level, clamp to it at once and turn the ramp downward.
          S_FLASH_OFF: begin
            color_code <= color_code_in;
            lamp_on    <= 1'b1;
            if ((brightness > brightness_in) || (tick && brightness >= brightness_in)) begin
              brightness <= brightness_in;
              state_q    <= S_FLASH_ON;
            end else if (tick) begin
              brightness <= brightness + 4'd1;
              if ((brightness + 4'd1) >= brightness_in) state_q <= S_FLASH_ON;
            end
          end
`else
          // Lit phase: follow the requested colour until the tick blanks the lamp.
          S_FLASH_ON: begin
            if (tick) begin
              state_q    <= S_FLASH_OFF;
              brightness <= 4'd0;
              lamp_on    <= 1'b0;
            end else begin
              color_code <= color_code_in;
              brightness <= brightness_in;
              lamp_on    <= 1'b1;
            end
          end

          // Dark phase: the colour code holds its last value while the lamp is off.
          S_FLASH_OFF: begin
            if (tick) begin
              state_q    <= S_FLASH_ON;
              color_code <= color_code_in;
              brightness <= brightness_in;
              lamp_on    <= 1'b1;
            end else begin
              brightness <= 4'd0;
              lamp_on    <= 1'b0;
            end
          end
`endif

          S_RAINBOW: begin
            if (tick) idx <= idx_next;
            color_code <= tick ? idx_next : idx;
            brightness <= brightness_in;
            lamp_on    <= 1'b1;
          end

          default: begin
            state_q    <= S_OFF;
            color_code <= 4'd0;
            brightness <= 4'd0;
            lamp_on    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Self-checking bench for led_mode_sequencer.
// A behavioural reference model, driven by the same inputs, predicts every
// output. A compare process checks it on every falling edge, and directed
// literal expectations pin the model itself.
module tb_led_mode_sequencer;

  localparam int DIV_W      = 16;
  localparam int NUM_COLORS = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       mode;
  logic [3:0]       color_code_in;
  logic [3:0]       brightness_in;
  logic [DIV_W-1:0] period;
  logic [3:0]       color_code;
  logic [3:0]       brightness;
  logic             lamp_on;
  logic             step;
  logic [2:0]       state;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  led_mode_sequencer #(.DIV_W(DIV_W), .NUM_COLORS(NUM_COLORS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .color_code_in(color_code_in),
    .brightness_in(brightness_in),
    .period       (period),
    .color_code   (color_code),
    .brightness   (brightness),
    .lamp_on      (lamp_on),
    .step         (step),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Prescaler position, the current phase (0 off, 1 solid, 2 lit/down,
  // 3 dark/up, 4 rainbow) and the rainbow colour. The outputs follow from the
  // phase reached after each edge.
  logic [1:0] m_mode_q;
  int         m_state, m_cnt, m_idx, m_fb;
  logic [3:0] m_cc, m_br;
  logic       m_lamp, m_step;

  always @(posedge clk or negedge rst_n) begin : ref_model
    int   ns, nc, ni, nfb;
    bit   tick;
    logic [3:0] ncc, nbr;
    logic nlamp;
    if (!rst_n) begin
      m_mode_q <= 2'd0;
      m_state  <= 0;
      m_cnt    <= 0;
      m_idx    <= 0;
      m_fb     <= 0;
      m_cc     <= 4'd0;
      m_br     <= 4'd0;
      m_lamp   <= 1'b0;
      m_step   <= 1'b0;
    end else begin
      ns = m_state; ni = m_idx; nfb = m_fb; tick = 1'b0; nc = 0;
      if (mode != m_mode_q) begin
        ns  = (mode == 2'd3) ? 4 : int'(mode);
        nfb = int'(brightness_in);
        if (ns == 4) ni = (int'(color_code_in) < NUM_COLORS) ? int'(color_code_in) : 0;
      end else if (m_state != 0) begin
        tick = (m_cnt >= int'(period));
        nc   = tick ? 0 : m_cnt + 1;
        if (tick && m_state == 4) ni = (m_idx + 1) % NUM_COLORS;
`ifdef LED_SEQ_FADE_EN
        if (m_state == 2 && tick) begin
          if (nfb > 0) nfb = nfb - 1;
          if (nfb == 0) ns = 3;
        end else if (m_state == 3) begin
          if (nfb > int'(brightness_in) || (tick && nfb >= int'(brightness_in))) begin
            nfb = int'(brightness_in);
            ns  = 2;
          end else if (tick) begin
            nfb = nfb + 1;
            if (nfb >= int'(brightness_in)) ns = 2;
          end
        end
`else
        if (tick && m_state == 2) ns = 3;
        else if (tick && m_state == 3) ns = 2;
`endif
      end
      case (ns)
        1, 2: begin ncc = color_code_in; nbr = brightness_in; nlamp = 1'b1; end
        3:    begin ncc = m_cc;          nbr = 4'd0;          nlamp = 1'b0; end
        4:    begin ncc = 4'(ni);        nbr = brightness_in; nlamp = 1'b1; end
        default: begin ncc = 4'd0;       nbr = 4'd0;          nlamp = 1'b0; end
      endcase
`ifdef LED_SEQ_FADE_EN
      if (ns == 2 || ns == 3) begin ncc = color_code_in; nbr = 4'(nfb); nlamp = 1'b1; end
`endif
      m_mode_q <= mode;
      m_state  <= ns;
      m_cnt    <= nc;
      m_idx    <= ni;
      m_fb     <= nfb;
      m_cc     <= ncc;
      m_br     <= nbr;
      m_lamp   <= nlamp;
      m_step   <= tick && (m_state != 1);
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en)
      check("cycle", {2'b00, state, color_code, brightness, lamp_on, step},
            {2'b00, 3'(m_state), m_cc, m_br, m_lamp, m_step});
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // Stimulus and directed literal expectations.
  initial begin : stim
    bit   lamp_exp [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
    bit   step_exp [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    logic [3:0] rb_exp [4] = '{4'd8, 4'd9, 4'd0, 4'd1};
    int   r;

    rst_n = 1'b0; mode = 2'd0; color_code_in = 4'd2; brightness_in = 4'd9; period = 16'd3;
    repeat (3) nxt();
    chk_en = 1'b1;
    check("reset_out", {2'b00, state, color_code, brightness, lamp_on, step}, 16'h0000);
    rst_n = 1'b1;
    nxt();

    // Flash with period 3: four lit cycles then four dark cycles.
    mode = 2'd2;
    for (int i = 0; i < 9; i++) begin
      nxt();
`ifndef LED_SEQ_FADE_EN
      check($sformatf("flash_lamp%0d", i), 16'(lamp_on), 16'(lamp_exp[i]));
`endif
      check($sformatf("flash_step%0d", i), 16'(step), 16'(step_exp[i]));
    end
    // After the tick at sample 8, cnt reaches 2 two edges later. Dropping period to 0 ticks at once.
    nxt(); nxt();
    period = 16'd0;
    nxt();
    check("period_drop_step", 16'(step), 16'd1);
`ifndef LED_SEQ_FADE_EN
    check("period_drop_lamp", 16'(lamp_on), 16'd0);
`endif

    // Reset mid-flash takes effect without a clock edge.
    rst_n = 1'b0;
    #1;
    check("async_reset", {2'b00, state, color_code, brightness, lamp_on, step}, 16'h0000);
    mode = 2'd0;
    nxt(); nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      check("off_after_reset", {2'b00, state, color_code, brightness, lamp_on, step}, 16'h0000);
    end

    // Solid colour tracks the inputs one clock later.
    mode = 2'd1; color_code_in = 4'd5; brightness_in = 4'd15;
    nxt();
    check("solid_out", {7'd0, color_code, brightness, lamp_on}, {7'd0, 4'd5, 4'd15, 1'b1});
    brightness_in = 4'd7;
    nxt();
    check("solid_bright", 16'(brightness), 16'd7);
    check("solid_step", 16'(step), 16'd0);

    // Rainbow from 8 wraps through 9 to 0.
    period = 16'd0; color_code_in = 4'd8; mode = 2'd3;
    for (int i = 0; i < 4; i++) begin
      nxt();
      check($sformatf("rainbow%0d", i), 16'(color_code), 16'(rb_exp[i]));
    end
    mode = 2'd0;
    nxt();
    color_code_in = 4'd12; mode = 2'd3;
    nxt();
    check("rainbow_oob_start", 16'(color_code), 16'd0);
    nxt();
    check("rainbow_oob_next", 16'(color_code), 16'd1);

    // Mode change on the edge where cnt == period beats the tick.
    mode = 2'd0;
    nxt();
    color_code_in = 4'd4; period = 16'd2; mode = 2'd3;
    nxt(); nxt(); nxt();
    mode = 2'd2;
    nxt();
    check("chg_state", 16'(state), 16'd2);
    check("chg_step", 16'(step), 16'd0);
    nxt(); nxt();
    check("chg_no_early_tick", 16'(step), 16'd0);
    nxt();
    check("chg_first_tick", 16'(step), 16'd1);
`ifndef LED_SEQ_FADE_EN
    check("chg_first_tick_lamp", 16'(lamp_on), 16'd0);
`endif

`ifdef LED_SEQ_FADE_EN
    // Breathe: brightness ramps 3,2,1,0,1,2,3,2 with the lamp held on.
    begin
      logic [3:0] fade_exp [8] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2, 4'd3, 4'd2};
      mode = 2'd0;
      nxt();
      brightness_in = 4'd3; period = 16'd0; mode = 2'd2;
      for (int i = 0; i < 8; i++) begin
        nxt();
        check($sformatf("fade%0d", i), {11'd0, brightness, lamp_on}, {11'd0, fade_exp[i], 1'b1});
      end
    end
`endif

    // Randomised run, checked each cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8)       mode          = 2'($urandom_range(0, 3));
      if (r % 5 == 0)  color_code_in = 4'($urandom_range(0, 15));
      if (r % 7 == 0)  brightness_in = 4'($urandom_range(0, 15));
      if (r < 4)       period        = 16'($urandom_range(0, 6));
      if (r == 99) begin
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
      end
      nxt();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
